// File: rtl/digit_grid_capture.sv
// digit_grid_capture: arms on request, captures one frame's square window of
// the luma stream and reduces it to an 11x11 grid of 8-bit cell averages.
// The grid is published atomically on a single-cycle grid_valid pulse.
module digit_grid_capture #(
  parameter int unsigned X0        = 100,
  parameter int unsigned Y0        = 50,
  parameter int unsigned LOG2_CELL = 2,
  parameter int unsigned XY_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_req,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [XY_W-1:0]   pix_x,
  input  logic [XY_W-1:0]   pix_y,
  input  logic [7:0]        pix_data,
  output logic              busy,
  output logic [967:0]      grid,
  output logic              grid_valid
);

  localparam int unsigned GRID_N = 11;
  localparam int unsigned CELL   = 1 << LOG2_CELL;
  localparam int unsigned WIN    = GRID_N * CELL;
  localparam int unsigned ACC_W  = 8 + 2 * LOG2_CELL;
  localparam int unsigned GRID_W = GRID_N * GRID_N * 8;
  localparam int unsigned BASE_W = $clog2(GRID_W);
  localparam int unsigned IDX_W  = 4;

  localparam logic [XY_W-1:0] X_LO = XY_W'(X0);
  localparam logic [XY_W-1:0] X_HI = XY_W'(X0 + WIN);
  localparam logic [XY_W-1:0] Y_LO = XY_W'(Y0);
  localparam logic [XY_W-1:0] Y_HI = XY_W'(Y0 + WIN);
  localparam logic [XY_W-1:0] LAST = XY_W'(WIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_CAPTURE,
    S_PUBLISH
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc [GRID_N];
  logic [GRID_W-1:0]  work;

  logic [XY_W-1:0]    dx;
  logic [XY_W-1:0]    dy;
  logic               in_win;
  logic [IDX_W-1:0]   col;
  logic [IDX_W-1:0]   row;
  logic               cell_close;
  logic               final_pix;
  logic [ACC_W-1:0]   cell_sum;
  logic [7:0]         cell_avg;
  logic [BASE_W-1:0]  cell_base;

  // Window membership, cell addressing and the closing-cell average
  always_comb begin
    dx         = pix_x - X_LO;
    dy         = pix_y - Y_LO;
    in_win     = pix_valid &&
                 (pix_x >= X_LO) && (pix_x < X_HI) &&
                 (pix_y >= Y_LO) && (pix_y < Y_HI);
    col        = IDX_W'(dx >> LOG2_CELL);
    row        = IDX_W'(dy >> LOG2_CELL);
    cell_close = (&dx[LOG2_CELL-1:0]) && (&dy[LOG2_CELL-1:0]);
    final_pix  = (dx == LAST) && (dy == LAST);
    cell_sum   = '0;
    if (col < IDX_W'(GRID_N)) begin
      cell_sum = acc[col] + ACC_W'(pix_data);
    end
    cell_avg   = 8'(cell_sum >> (2 * LOG2_CELL));
    cell_base  = BASE_W'((32'(row) * GRID_N + 32'(col)) * 8);
  end

  // Control FSM with registered busy/grid/grid_valid plus the accumulator datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      grid_valid <= 1'b0;
      grid       <= '0;
      work       <= '0;
      for (int i = 0; i < GRID_N; i++) begin
        acc[i] <= '0;
      end
    end else begin
      grid_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (capture_req) begin
            state <= S_WAIT_FRAME;
            busy  <= 1'b1;
          end
        end
        S_WAIT_FRAME: begin
          if (frame_start) begin
            state <= S_CAPTURE;
            work  <= '0;
            for (int i = 0; i < GRID_N; i++) begin
              acc[i] <= '0;
            end
          end
        end
        S_CAPTURE: begin
          if (frame_start) begin
            // Restart: drop partial sums, keep the published grid untouched
            work <= '0;
            for (int i = 0; i < GRID_N; i++) begin
              acc[i] <= '0;
            end
          end else if (in_win) begin
            if (cell_close) begin
              work[cell_base +: 8] <= cell_avg;
              acc[col]             <= '0;
            end else begin
              acc[col] <= cell_sum;
            end
            if (final_pix) begin
              state <= S_PUBLISH;
              busy  <= 1'b0;
            end
          end
        end
        S_PUBLISH: begin
          grid       <= work;
          grid_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/digit_grid_capture.md
Name: digit_grid_capture

Overview:
- Producer end of the digit-template interface. Captures a square window of the incoming luma pixel stream and reduces it to an 11x11 grid of 8-bit cell averages.
- The result is presented as one flat bus. The per-digit difference blocks and the classifier consume this bus as their 11x11 input image.
- Capture is armed on request and runs for one frame. The grid is published atomically when the window completes.

Parameters:
- X0, 100, window left column (pixel x of grid column 0).
- Y0, 50, window top line (pixel y of grid row 0).
- LOG2_CELL, 2, log2 of cell edge in pixels. Cell is 2^LOG2_CELL square; window is 11*2^LOG2_CELL square.
- XY_W, 10, width of the pixel coordinate inputs.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- capture_req  in  1  one-cycle pulse; arms a capture.
- frame_start  in  1  one-cycle pulse, precedes the first pixel of each frame.
- pix_valid  in  1  pixel qualifier.
- pix_x  in  XY_W  pixel column.
- pix_y  in  XY_W  pixel line.
- pix_data  in  8  pixel luma.
- busy  out  1  high in WAIT_FRAME and CAPTURE.
- grid  out  968  published grid. Row r, column c sits at bits [(r*11+c)*8 +: 8]; r and c run 0..10, row-major.
- grid_valid  out  1  one-cycle pulse when grid updates.

Behaviour:
- Clock and reset: single clock domain. Asynchronous active-high reset forces:
  - state IDLE, busy=0, grid_valid=0, grid=0;
  - all accumulators and the working grid cleared.
- States:
  - IDLE: capture_req -> WAIT_FRAME.
  - WAIT_FRAME: frame_start -> CAPTURE, clearing the 11 column accumulators and the working grid.
  - CAPTURE: accumulate window pixels. Final window pixel -> PUBLISH.
  - PUBLISH: one cycle. Copy working grid to grid, grid_valid=1, -> IDLE.
- busy is a registered decode of the state: 1 in WAIT_FRAME and CAPTURE, 0 in IDLE and PUBLISH.
- Window membership: a pixel is in the window when pix_valid=1, X0 <= pix_x < X0+11*2^LOG2_CELL, and Y0 <= pix_y < Y0+11*2^LOG2_CELL. Pixels outside the window are ignored.
- Pixel order: pixels arrive in raster order, one per cycle at most, with gaps allowed.
- Cell index: dx=pix_x-X0, dy=pix_y-Y0, col=dx>>LOG2_CELL, row=dy>>LOG2_CELL.
- Accumulation: acc[col] += pix_data.
  - Each accumulator is 8+2*LOG2_CELL bits wide; no overflow is possible.
- Cell close: when the low LOG2_CELL bits of dx and of dy are all ones, write work[row][col] = (acc[col]+pix_data) >> (2*LOG2_CELL), truncating. In the same cycle acc[col] clears to 0.
- Final pixel: the pixel at dx=dy=11*2^LOG2_CELL-1 closes cell (10,10) and moves to PUBLISH.
  - grid and grid_valid change on the clock edge after PUBLISH is entered, i.e. 2 cycles after the final pixel is sampled.
- Hold: grid holds its value between publishes. An aborted capture never alters grid.
- Simultaneous events:
  - capture_req outside IDLE is ignored.
  - capture_req and frame_start in the same IDLE cycle: arm only; that frame_start is not taken.
  - frame_start in CAPTURE aborts the capture and restarts it: accumulators and working grid clear, state stays CAPTURE, no grid_valid.
  - frame_start and pix_valid in the same cycle: the pixel is ignored.
  - pix_valid in IDLE, WAIT_FRAME or PUBLISH: ignored.
- Reset mid-operation: immediate return to reset values. A capture in progress is lost; no grid_valid.

Test Plan:
- Default parameters, capture_req, frame_start, then a full 640x480 raster of constant 128 -> all 121 grid bytes equal 128. grid_valid pulses once, 2 cycles after pixel (143,93); busy falls in the cycle after that pixel.
- Each window pixel = (row*11+col) of its cell; outside the window = 255 -> grid byte (r,c) = r*11+c, e.g. byte 120 = 120, byte 0 = 0. Out-of-window 255 values do not leak into any byte.
- Cell (0,0) pixels 0,16,...,240 in raster order, all other cells 0 -> byte (0,0) = 120, all other bytes 0.
- Abort: after capture of known grid A, arm again, send half the window, then frame_start, then a full frame of 50:
  - no grid_valid during the partial frame;
  - grid stays A until the new publish, then all 121 bytes = 50.
- No capture_req: two full frames -> busy=0, grid_valid never asserted, grid unchanged. capture_req pulses during CAPTURE do not cause extra publishes.
- Assert reset asynchronously mid-window after a prior publish -> grid=0, busy=0, grid_valid=0 immediately without a clock edge. The next armed frame publishes correctly.
